// File: rtl/inst_encoder.sv
// ============================================================================
//  Module      : inst_encoder
//  Description : RV32I instruction encoder. Accepts decoded instruction fields
//                plus an immediate over a valid/ready handshake, assembles the
//                32-bit RV32I word according to the opcode's format
//                (R/I/S/B/U/J), and presents it on a registered valid/ready
//                output together with a word-aligned instruction-memory byte
//                address taken from an internal address counter.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    ADDR_W      width of the address counter and out_addr
//    COUNT_W     width of the emitted-instruction counter
//    RESET_ADDR  address counter value after reset (bits [1:0] ignored)
//
//  Ports
//    clk, rst_n          clock (rising edge) / asynchronous active-low reset
//    in_valid/in_ready   input handshake; in_ready = !out_valid || out_ready
//    in_opcode .. in_imm decoded fields and immediate to encode
//    load_base/base_addr reload the address counter (word aligned)
//    out_valid/out_ready output handshake
//    out_instruction     encoded word (NOP for unsupported opcodes)
//    out_addr            byte address assigned to out_instruction
//    out_illegal         opcode was not a supported RV32I opcode
//    out_misaligned      B/J immediate had bit 0 set (bit dropped)
//    inst_count          number of accepted bundles, saturating
// ============================================================================
`default_nettype none

module inst_encoder #(
  parameter int                ADDR_W     = 32,
  parameter int                COUNT_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  // field bundle input
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [6:0]         in_opcode,
  input  logic [4:0]         in_rd,
  input  logic [2:0]         in_funct3,
  input  logic [4:0]         in_rs1,
  input  logic [4:0]         in_rs2,
  input  logic [6:0]         in_funct7,
  input  logic [31:0]        in_imm,
  // address counter reload
  input  logic               load_base,
  input  logic [ADDR_W-1:0]  base_addr,
  // encoded word output
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instruction,
  output logic [ADDR_W-1:0]  out_addr,
  output logic               out_illegal,
  output logic               out_misaligned,
  output logic [COUNT_W-1:0] inst_count
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;

  // addi x0, x0, 0 -- substituted for unsupported opcodes
  localparam logic [31:0] c_NOP = 32'h0000_0013;

  localparam logic [ADDR_W-1:0]  c_ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0]  c_ADDR_STEP  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0]  c_RESET_PC   = RESET_ADDR & c_ALIGN_MASK;
  localparam logic [COUNT_W-1:0] c_COUNT_MAX  = '1;

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  logic               r_out_valid;
  logic [31:0]        r_instruction;
  logic [ADDR_W-1:0]  r_out_addr;
  logic               r_illegal;
  logic               r_misaligned;
  logic [COUNT_W-1:0] r_count;
  logic [ADDR_W-1:0]  r_pc;          // next address to hand out

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic w_in_ready;
  logic w_accept;

  // The output slot can take a new word when it is empty or being drained this
  // cycle. Gating with rst_n keeps the input side closed while held in reset.
  assign w_in_ready = rst_n & (~r_out_valid | out_ready);
  assign w_accept   = in_valid & w_in_ready;

  // --------------------------------------------------------------------------
  // Address selection
  // --------------------------------------------------------------------------
  logic [ADDR_W-1:0] w_base_aligned;
  logic [ADDR_W-1:0] w_slot_addr;

  assign w_base_aligned = base_addr & c_ALIGN_MASK;
  // A reload coinciding with an accept applies to the word being accepted.
  assign w_slot_addr    = load_base ? w_base_aligned : r_pc;

  // --------------------------------------------------------------------------
  // Format assembly
  // --------------------------------------------------------------------------
  logic [31:0] w_word;
  logic        w_illegal;
  logic        w_misaligned;

  always_comb begin
    w_word       = c_NOP;
    w_illegal    = 1'b0;
    w_misaligned = 1'b0;
    case (in_opcode)
      c_OP_R: begin
        w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      end
      c_OP_IMM, c_OP_LOAD, c_OP_JALR, c_OP_SYSTEM: begin
        w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      end
      c_OP_STORE: begin
        w_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0],
                  in_opcode};
      end
      c_OP_BRANCH: begin
        // Branch offsets are in halfwords; imm[0] has no slot and is dropped.
        w_word       = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], in_opcode};
        w_misaligned = in_imm[0];
      end
      c_OP_LUI, c_OP_AUIPC: begin
        w_word = {in_imm[31:12], in_rd, in_opcode};
      end
      c_OP_JAL: begin
        w_word       = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                        in_rd, in_opcode};
        w_misaligned = in_imm[0];
      end
      default: begin
        w_word    = c_NOP;
        w_illegal = 1'b1;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output register, address counter and instruction counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_instruction <= '0;
      r_out_addr    <= '0;
      r_illegal     <= 1'b0;
      r_misaligned  <= 1'b0;
      r_count       <= '0;
      r_pc          <= c_RESET_PC;
    end else begin
      if (w_accept) begin
        r_out_valid   <= 1'b1;
        r_instruction <= w_word;
        r_out_addr    <= w_slot_addr;
        r_illegal     <= w_illegal;
        r_misaligned  <= w_misaligned;
        r_pc          <= w_slot_addr + c_ADDR_STEP;  // wraps modulo 2^ADDR_W
        if (r_count != c_COUNT_MAX) begin
          r_count <= r_count + COUNT_W'(1);
        end
      end else begin
        // Word drained with nothing new behind it: drop valid, keep payload.
        if (out_ready) begin
          r_out_valid <= 1'b0;
        end
        if (load_base) begin
          r_pc <= w_base_aligned;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign in_ready        = w_in_ready;
  assign out_valid       = r_out_valid;
  assign out_instruction = r_instruction;
  assign out_addr        = r_out_addr;
  assign out_illegal     = r_illegal;
  assign out_misaligned  = r_misaligned;
  assign inst_count      = r_count;

endmodule

`default_nettype wire

// File: tb/tb_inst_encoder.sv
// ============================================================================
//  Module      : tb_inst_encoder
//  Description : Self-checking bench for inst_encoder. Directed vectors with
//                known-good encodings, then randomized traffic compared
//                against a cycle-level behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_encoder;

  localparam int ADDR_W  = 32;
  localparam int COUNT_W = 4;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [2:0]        in_funct3;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              load_base;
  logic [31:0]       base_addr;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instruction;
  logic [31:0]       out_addr;
  logic              out_illegal;
  logic              out_misaligned;
  logic [COUNT_W-1:0] inst_count;

  inst_encoder #(
    .ADDR_W    (ADDR_W),
    .COUNT_W   (COUNT_W),
    .RESET_ADDR(32'h0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_opcode      (in_opcode),
    .in_rd          (in_rd),
    .in_funct3      (in_funct3),
    .in_rs1         (in_rs1),
    .in_rs2         (in_rs2),
    .in_funct7      (in_funct7),
    .in_imm         (in_imm),
    .load_base      (load_base),
    .base_addr      (base_addr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instruction(out_instruction),
    .out_addr       (out_addr),
    .out_illegal    (out_illegal),
    .out_misaligned (out_misaligned),
    .inst_count     (inst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Behavioural model
  // --------------------------------------------------------------------------
  bit          m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_addr;
  bit          m_ill;
  bit          m_mis;
  int          m_count;
  logic [31:0] m_pc;
  int          count_max;

  // Field placement written as shifted/masked arithmetic from the format table.
  function automatic void model_encode(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [2:0] f3, input logic [4:0] rs1,
                                       input logic [4:0] rs2, input logic [6:0] f7,
                                       input logic [31:0] imm, output logic [31:0] w,
                                       output bit ill, output bit mis);
    logic [31:0] o, d, f, s1, s2, g;
    o = 32'(op); d = 32'(rd) << 7; f = 32'(f3) << 12;
    s1 = 32'(rs1) << 15; s2 = 32'(rs2) << 20; g = 32'(f7) << 25;
    ill = 0; mis = 0;
    case (op)
      7'h33: w = g | s2 | s1 | f | d | o;
      7'h13, 7'h03, 7'h67, 7'h73: w = ((imm & 32'hFFF) << 20) | s1 | f | d | o;
      7'h23: w = (((imm >> 5) & 32'h7F) << 25) | s2 | s1 | f | ((imm & 32'h1F) << 7) | o;
      7'h63: begin
        w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | s2 | s1 | f
          | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7) | o;
        mis = imm[0];
      end
      7'h37, 7'h17: w = (imm & 32'hFFFF_F000) | d | o;
      7'h6F: begin
        w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
          | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | d | o;
        mis = imm[0];
      end
      default: begin w = 32'h13; ill = 1; end
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_instr = 0; m_addr = 0; m_ill = 0; m_mis = 0;
    m_count = 0; m_pc = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".out_valid"},  32'(out_valid), 32'(m_valid));
    check({tag, ".out_instr"},  out_instruction, m_instr);
    check({tag, ".out_addr"},   out_addr, m_addr);
    check({tag, ".out_illegal"}, 32'(out_illegal), 32'(m_ill));
    check({tag, ".out_misal"},  32'(out_misaligned), 32'(m_mis));
    check({tag, ".inst_count"}, 32'(inst_count), m_count);
  endtask

  // One clock: entered just after a falling edge with inputs already driven.
  task automatic step(input string tag);
    bit exp_ready, acc;
    logic [31:0] w, a;
    bit ill, mis;
    #1;
    exp_ready = !m_valid || out_ready;
    check({tag, ".in_ready"}, 32'(in_ready), 32'(exp_ready));
    acc = in_valid && exp_ready;
    if (acc) begin
      model_encode(in_opcode, in_rd, in_funct3, in_rs1, in_rs2, in_funct7, in_imm, w, ill, mis);
      a = load_base ? (base_addr & ~32'h3) : m_pc;
      m_valid = 1; m_instr = w; m_addr = a; m_ill = ill; m_mis = mis;
      m_pc = a + 32'd4;
      if (m_count < count_max) m_count++;
    end else begin
      if (out_ready) m_valid = 0;
      if (load_base) m_pc = base_addr & ~32'h3;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic send(input string tag, input logic [6:0] op, input logic [4:0] rd,
                      input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [6:0] f7, input logic [31:0] imm);
    in_valid = 1; out_ready = 1; load_base = 0;
    in_opcode = op; in_rd = rd; in_funct3 = f3; in_rs1 = rs1; in_rs2 = rs2;
    in_funct7 = f7; in_imm = imm;
    step(tag);
  endtask

  logic [6:0] op_tab [10];

  initial begin
    count_max = (1 << COUNT_W) - 1;
    op_tab = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    rst_n = 0; in_valid = 0; out_ready = 0; load_base = 0; base_addr = 0;
    in_opcode = 0; in_rd = 0; in_funct3 = 0; in_rs1 = 0; in_rs2 = 0; in_funct7 = 0; in_imm = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset.in_ready", 32'(in_ready), 32'h0);
    check_outputs("reset");
    rst_n = 1;

    // Directed vectors with independently known encodings
    send("R_add", 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'h0);
    check("R_add.golden", out_instruction, 32'h002081B3);
    check("R_add.addr", out_addr, 32'h0);
    check("R_add.count", 32'(inst_count), 32'd1);
    send("I_addi", 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'hFFFF_FFFF);
    check("I_addi.golden", out_instruction, 32'hFFF00093);
    check("I_addi.addr", out_addr, 32'h4);
    send("S_sw", 7'h23, 5'd0, 3'd2, 5'd1, 5'd2, 7'd0, 32'd8);
    check("S_sw.golden", out_instruction, 32'h0020A423);
    send("B_beq", 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'hFFFF_FFFC);
    check("B_beq.golden", out_instruction, 32'hFE208EE3);
    send("J_jal", 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h800);
    check("J_jal.golden", out_instruction, 32'h001000EF);
    send("B_misal", 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'h5);
    check("B_misal.golden", out_instruction, 32'h00208263);
    check("B_misal.flag", 32'(out_misaligned), 32'h1);
    send("U_lui", 7'h37, 5'd5, 3'd0, 5'd0, 5'd0, 7'd0, 32'h1234_5000);
    check("U_lui.golden", out_instruction, 32'h123452B7);
    send("illegal", 7'h7F, 5'd7, 3'd1, 5'd2, 5'd3, 7'd1, 32'h1234);
    check("illegal.golden", out_instruction, 32'h00000013);
    check("illegal.flag", 32'(out_illegal), 32'h1);
    check("illegal.addr", out_addr, 32'h1C);

    // Backpressure: held word must stay frozen, then drain + accept together
    in_valid = 1; out_ready = 0; in_opcode = 7'h33; in_rd = 5'd9; in_rs1 = 5'd4; in_rs2 = 5'd6;
    for (int i = 0; i < 3; i++) begin
      step("bp_hold");
      check("bp_hold.frozen", out_instruction, 32'h00000013);
    end
    out_ready = 1;
    step("bp_release");
    check("bp_release.addr", out_addr, 32'h20);
    in_valid = 0;
    step("bp_drain");

    // Base reload coinciding with an accept, then plain accept
    in_valid = 1; load_base = 1; base_addr = 32'h103;
    step("base_acc");
    check("base_acc.addr", out_addr, 32'h100);
    load_base = 0;
    step("base_next");
    check("base_next.addr", out_addr, 32'h104);

    // Reload without accept, then wrap at the top of the address space
    in_valid = 0; load_base = 1; base_addr = 32'hFFFF_FFFC;
    step("base_idle");
    load_base = 0; in_valid = 1;
    step("wrap0");
    check("wrap0.addr", out_addr, 32'hFFFF_FFFC);
    step("wrap1");
    check("wrap1.addr", out_addr, 32'h0);

    // Saturation of the narrow count
    for (int i = 0; i < 4; i++) step("sat");
    check("sat.count", 32'(inst_count), 32'hF);

    // Asynchronous reset in the middle of a cycle
    #2;
    rst_n = 0;
    #1;
    model_reset();
    check("async_rst.in_ready", 32'(in_ready), 32'h0);
    check_outputs("async_rst");
    @(negedge clk);
    rst_n = 1; in_valid = 0;
    step("post_rst");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int sel;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      load_base = ($urandom_range(0, 19) == 0);
      base_addr = $urandom;
      sel = $urandom_range(0, 10);
      in_opcode = (sel == 10) ? 7'($urandom) : op_tab[sel];
      in_rd = 5'($urandom); in_funct3 = 3'($urandom); in_rs1 = 5'($urandom);
      in_rs2 = 5'($urandom); in_funct7 = 7'($urandom); in_imm = $urandom;
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inst_encoder.md
# inst_encoder

Instruction encoder for the RV32I datapath: the inverse of the field decoder in front of the register file. It accepts decoded fields plus an immediate over a valid/ready handshake and assembles the 32-bit RV32I word by opcode format (R/I/S/B/U/J). It outputs each word on a registered valid/ready port together with a word-aligned instruction-memory address from an internal counter. It feeds the instruction-memory loader and the self-checking round-trip bench (encoder → memory → decoder).

## Interface
- ADDR_W, 32, width of the address counter and of out_addr
- COUNT_W, 16, width of the emitted-instruction counter
- RESET_ADDR, 0, address counter value after reset; bits [1:0] ignored (treated as 00)

- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder can accept this cycle
- in_opcode  input  7  opcode, selects format
- in_rd  input  5  destination register
- in_funct3  input  3  funct3
- in_rs1  input  5  source register 1
- in_rs2  input  5  source register 2
- in_funct7  input  7  funct7 (R-type only)
- in_imm  input  32  immediate, sign-extended byte offset (B/J) or full value (I/S); U-type uses in_imm[31:12]
- load_base  input  1  load address counter from base_addr this cycle
- base_addr  input  ADDR_W  new counter value; bits [1:0] forced to 00
- out_valid  output  1  out_* holds an encoded word
- out_ready  input  1  consumer takes word when out_valid && out_ready
- out_instruction  output  32  encoded word
- out_addr  output  ADDR_W  memory byte address assigned to out_instruction
- out_illegal  output  1  opcode not supported; out_instruction is NOP
- out_misaligned  output  1  B/J immediate with in_imm[0]=1; bit 0 dropped
- inst_count  output  COUNT_W  number of accepted bundles; saturates at all-ones

## Operation
- Formats by in_opcode:
  - R (0110011): funct7|rs2|rs1|funct3|rd|op
  - I (0010011, 0000011, 1100111, 1110011): imm[11:0]|rs1|funct3|rd|op
  - S (0100011): imm[11:5]|rs2|rs1|funct3|imm[4:0]|op
  - B (1100011): imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op
  - U (0110111, 0010111): imm[31:12]|rd|op
  - J (1101111): imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op
- Immediate bits not listed for a format are ignored. No range checking is done beyond in_imm[0] for B/J.
- Any other opcode produces out_instruction = 0x00000013 with out_illegal=1. The bundle still consumes an address and a count.
- out_misaligned=1 only for B/J with in_imm[0]=1. It is 0 otherwise.
- Address counter: on accept, out_addr ← counter and counter ← counter+4, modulo 2^ADDR_W (0xFFFFFFFC → 0x00000000 for ADDR_W=32).
- load_base without accept: counter ← {base_addr[ADDR_W-1:2],2'b00}.
- load_base with accept: the accepted word gets the loaded base, and counter ← base+4.
- inst_count increments by 1 on each accept and holds at 2^COUNT_W−1.

## Timing
- Reset (async, immediate) sets: out_valid=0, out_instruction=0, out_addr=0, out_illegal=0, out_misaligned=0, inst_count=0, counter=RESET_ADDR&~3.
- in_ready = !out_valid || out_ready, combinational. It is 0 while rst_n=0.
- Accept = in_valid && in_ready. Latency is 1 cycle: the accept at edge N is visible on out_* after edge N.
- Throughput is 1 word/cycle with out_ready held high.
- While out_valid && !out_ready, all out_* are stable and no accept occurs.
- If out_valid && out_ready with no new accept, out_valid falls to 0 next edge. The other out_* hold their last values.
- Reset mid-stream discards the held word. The first accept after reset is assigned RESET_ADDR.
- The in_* inputs are sampled only on an accept edge.

## Test plan
- R add x3,x1,x2 (funct7=0, f3=0), out_ready=1 → 0x002081B3 one cycle later, out_addr=0x0, inst_count=1.
- I addi x1,x0,imm=0xFFFFFFFF → 0xFFF00093. S sw x2,8(x1) → 0x0020A423. Back-to-back accepts give out_addr 0x0 then 0x4.
- B beq x1,x2,imm=−4 → 0xFE208EE3. J jal x1,imm=0x800 → 0x001000EF. B with imm=0x5 → out_misaligned=1, encoded as imm=0x4.
- U lui x5,imm=0x12345000 → 0x123452B7. Opcode 0x7F → 0x00000013 with out_illegal=1, and the address still advances by 4.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0 and out_* frozen. Raising out_ready drains the held word and accepts the next bundle in the same cycle, with no loss or duplication.
- Address/count boundaries:
  - load_base=1 with base_addr=0x103 during an accept → out_addr=0x100, next address 0x104.
  - base_addr=0xFFFFFFFC followed by two accepts → out_addr 0xFFFFFFFC, then 0x0.
  - inst_count preset near max by 2^COUNT_W accepts (COUNT_W=4 build) → saturates at 0xF.
  - rst_n low mid-stream → all outputs reset immediately, without waiting for a clock edge.
